// File: rtl/standby_led_ng.sv
// -----------------------------------------------------------------------------
// standby_led_ng
//   Parametrised LED status driver for the dice game. Shows an idle chase,
//   per-player score bars, a blinking final-round bar display and a blinking
//   winner display, all paced by an internal animation tick.
//
//   Optional feature macro: STANDBY_PWM_EN
//     defined   -> the IDLE chase is dimmed by a free-running 4-bit PWM
//                  counter (on while pwm_cnt < PWM_DUTY).
//     undefined -> IDLE runs at full brightness; PWM_DUTY is ignored.
//
// Parameters
//   LED_W     number of LEDs (even, >= 4); each player owns LED_W/2
//   SCORE_W   width of each score input
//   TICK_DIV  clk cycles per animation tick (>= 2)
//   PWM_DUTY  idle on-slots out of 16 (1..16), PWM build only
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   times      round in progress
//   is_final   current round is the final round
//   is_finish  game over (highest priority)
//   score1     player 1 score, unsigned
//   score2     player 2 score, unsigned
//   rgb_led    registered LED drive, 1 = on
//   winner     registered: 00 none, 01 P1, 10 P2, 11 tie (FINISH only)
// -----------------------------------------------------------------------------
module standby_led_ng #(
  parameter int LED_W    = 16,
  parameter int SCORE_W  = 4,
  parameter int TICK_DIV = 25_000_000,
  parameter int PWM_DUTY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               times,
  input  logic               is_final,
  input  logic               is_finish,
  input  logic [SCORE_W-1:0] score1,
  input  logic [SCORE_W-1:0] score2,
  output logic [LED_W-1:0]   rgb_led,
  output logic [1:0]         winner
);

  localparam int HALF  = LED_W / 2;
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int POS_W = $clog2(LED_W);

  // Elaboration-time parameter sanity checks.
  if ((LED_W % 2) != 0 || LED_W < 4) begin : g_bad_led_w
    $error("standby_led_ng: LED_W must be even and >= 4");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("standby_led_ng: TICK_DIV must be >= 2");
  end
  if (PWM_DUTY < 1 || PWM_DUTY > 16) begin : g_bad_pwm_duty
    $error("standby_led_ng: PWM_DUTY must be in 1..16");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUND  = 2'd1,
    ST_FINAL  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic               r_phase;
  logic [POS_W-1:0]   r_pos;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic [SCORE_W-1:0] r_lat1;
  logic [SCORE_W-1:0] r_lat2;

  state_t             w_next_state;
  logic               w_state_chg;
  logic               w_tick;
  logic               w_pwm_on;
  logic [1:0]         w_winner;
  logic [LED_W-1:0]   w_chase;
  logic [LED_W-1:0]   w_finish_leds;

  // Score bars: player 1 fills upward from bit 0, player 2 fills downward
  // from the top bit. Comparing against the bit index saturates naturally
  // at HALF.
  function automatic logic [LED_W-1:0] bar(input logic [SCORE_W-1:0] s1,
                                           input logic [SCORE_W-1:0] s2);
    logic [LED_W-1:0] v;
    v = '0;
    for (int i = 0; i < HALF; i++) begin
      v[i]           = (32'(s1) > 32'(i));
      v[LED_W-1-i]   = (32'(s2) > 32'(i));
    end
    return v;
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = ST_IDLE;
    if (is_finish)            w_next_state = ST_FINISH;
    else if (times && is_final) w_next_state = ST_FINAL;
    else if (times)           w_next_state = ST_ROUND;
  end

  assign w_state_chg = (w_next_state != r_state);
  assign w_tick      = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
  assign w_chase     = LED_W'(1) << r_pos;

  always_comb begin
    w_winner = 2'b11;
    if (r_lat1 > r_lat2)      w_winner = 2'b01;
    else if (r_lat2 > r_lat1) w_winner = 2'b10;
  end

  always_comb begin
    w_finish_leds = '1;
    if (w_winner == 2'b01)      w_finish_leds = {{HALF{1'b0}}, {HALF{1'b1}}};
    else if (w_winner == 2'b10) w_finish_leds = {{HALF{1'b1}}, {HALF{1'b0}}};
  end

`ifdef STANDBY_PWM_EN
  logic [3:0] r_pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_pwm_cnt <= '0;
    else     r_pwm_cnt <= r_pwm_cnt + 4'd1;
  end

  assign w_pwm_on = ({1'b0, r_pwm_cnt} < 5'(PWM_DUTY));
`else
  assign w_pwm_on = 1'b1;
`endif

  // Mode/animation registers are updated from the inputs at edge k; the
  // LED and winner registers are derived from those registers, so every
  // input effect reaches the outputs at edge k+1. Scores are registered
  // alongside the state to keep that two-stage latency uniform.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_phase    <= 1'b0;
      r_pos      <= '0;
      r_score1   <= '0;
      r_score2   <= '0;
      r_lat1     <= '0;
      r_lat2     <= '0;
      rgb_led    <= '0;
      winner     <= 2'b00;
    end else begin
      r_state  <= w_next_state;
      r_score1 <= score1;
      r_score2 <= score2;

      if (w_state_chg) begin
        // Restart the animation so every mode begins in phase.
        r_tick_cnt <= '0;
        r_phase    <= 1'b0;
        r_pos      <= '0;
        if (w_next_state == ST_FINISH) begin
          r_lat1 <= score1;
          r_lat2 <= score2;
        end
      end else if (w_tick) begin
        r_tick_cnt <= '0;
        r_phase    <= ~r_phase;
        r_pos      <= (r_pos == POS_W'(LED_W - 1)) ? '0 : r_pos + POS_W'(1);
      end else begin
        r_tick_cnt <= r_tick_cnt + CNT_W'(1);
      end

      unique case (r_state)
        ST_IDLE:   rgb_led <= w_pwm_on ? w_chase : '0;
        ST_ROUND:  rgb_led <= bar(r_score1, r_score2);
        ST_FINAL:  rgb_led <= r_phase ? '0 : bar(r_score1, r_score2);
        ST_FINISH: rgb_led <= r_phase ? '0 : w_finish_leds;
        default:   rgb_led <= '0;
      endcase

      winner <= (r_state == ST_FINISH) ? w_winner : 2'b00;
    end
  end

endmodule

// File: tb/tb_standby_led_ng.sv
// -----------------------------------------------------------------------------
// tb_standby_led_ng
//   Self-checking bench for standby_led_ng (LED_W=16, SCORE_W=4, TICK_DIV=4).
//   A behavioural model tracks the mode and the number of edges spent in it,
//   and derives the expected LEDs and winner arithmetically. A compare
//   process checks the DUT against it every cycle; directed scenarios add
//   hand-computed literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_standby_led_ng;

  localparam int LED_W    = 16;
  localparam int SCORE_W  = 4;
  localparam int TICK_DIV = 4;
  localparam int PWM_DUTY = 4;
  localparam int HALF     = LED_W / 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               times;
  logic               is_final;
  logic               is_finish;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [LED_W-1:0]   rgb_led;
  logic [1:0]         winner;

  int n_tests = 0;
  int n_fail  = 0;

  standby_led_ng #(
    .LED_W   (LED_W),
    .SCORE_W (SCORE_W),
    .TICK_DIV(TICK_DIV),
    .PWM_DUTY(PWM_DUTY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .times    (times),
    .is_final (is_final),
    .is_finish(is_finish),
    .score1   (score1),
    .score2   (score2),
    .rgb_led  (rgb_led),
    .winner   (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Modes: 0 idle, 1 round, 2 final, 3 finish.
  // m_n counts edges since the mode was entered (0 on the entry edge), so the
  // number of completed ticks is m_n / TICK_DIV.
  // ---------------------------------------------------------------------------
  int          m_mode = 0;
  int          m_n    = 0;
  int          m_s1   = 0;
  int          m_s2   = 0;
  int          m_l1   = 0;
  int          m_l2   = 0;
  int          m_pwm  = 0;
  bit          m_valid = 0;
  logic [15:0] exp_rgb = '0;
  logic [1:0]  exp_win = '0;

  function automatic logic [15:0] model_bar(input int a, input int b);
    logic [15:0] v;
    int na, nb;
    na = (a < HALF) ? a : HALF;
    nb = (b < HALF) ? b : HALF;
    v = '0;
    for (int i = 0; i < LED_W; i++)
      v[i] = (i < na) || (i >= LED_W - nb);
    return v;
  endfunction

  function automatic logic [1:0] model_winner(input int a, input int b);
    if (a > b) return 2'b01;
    if (b > a) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [15:0] model_leds();
    int ticks;
    logic [15:0] v;
    ticks = m_n / TICK_DIV;
    v = '0;
    case (m_mode)
      0: begin
        v = 16'h0001 << (ticks % LED_W);
`ifdef STANDBY_PWM_EN
        if (m_pwm >= PWM_DUTY) v = '0;
`endif
      end
      1: v = model_bar(m_s1, m_s2);
      2: v = (ticks % 2 == 1) ? 16'h0000 : model_bar(m_s1, m_s2);
      default: begin
        if (ticks % 2 == 1)      v = 16'h0000;
        else if (m_l1 > m_l2)    v = 16'h00FF;
        else if (m_l2 > m_l1)    v = 16'hFF00;
        else                     v = 16'hFFFF;
      end
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    int nm;
    m_valid = 1'b1;
    if (rst) begin
      exp_rgb = '0;
      exp_win = 2'b00;
      m_mode = 0; m_n = 0; m_s1 = 0; m_s2 = 0; m_l1 = 0; m_l2 = 0; m_pwm = 0;
    end else begin
      exp_rgb = model_leds();
      exp_win = (m_mode == 3) ? model_winner(m_l1, m_l2) : 2'b00;
      if (is_finish)              nm = 3;
      else if (times && is_final) nm = 2;
      else if (times)             nm = 1;
      else                        nm = 0;
      if (nm != m_mode) begin
        m_n = 0;
        if (nm == 3) begin
          m_l1 = int'(score1);
          m_l2 = int'(score2);
        end
      end else begin
        m_n++;
      end
      m_mode = nm;
      m_s1   = int'(score1);
      m_s2   = int'(score2);
      m_pwm  = (m_pwm + 1) % 16;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("rgb_led_model", 32'(rgb_led), 32'(exp_rgb));
      check("winner_model",  32'(winner),  32'(exp_win));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; times = 1'b0; is_final = 1'b0; is_finish = 1'b0;
    score1 = '0; score2 = '0;
    cycles(3);
    rst = 1'b0;

    // Reset / idle chase.
    cycles(1);
    check("idle_first", 32'(rgb_led), 32'h0001);
    check("idle_winner", 32'(winner), 32'h0);
`ifdef STANDBY_PWM_EN
    cycles(4);
    check("idle_pwm_gated", 32'(rgb_led), 32'h0000);
    cycles(60);
`else
    cycles(4);
    check("idle_shift", 32'(rgb_led), 32'h0002);
    cycles(60);
    check("idle_wrap", 32'(rgb_led), 32'h0001);
`endif

    // ROUND bars.
    times = 1'b1; score1 = 4'd5; score2 = 4'd3;
    cycles(2);
    check("round_bar", 32'(rgb_led), 32'hE01F);
    score1 = 4'd12;
    cycles(2);
    check("round_sat", 32'(rgb_led), 32'hE0FF);

    // FINAL blink.
    is_final = 1'b1; score1 = 4'd7; score2 = 4'd4;
    cycles(2);
    check("final_on", 32'(rgb_led), 32'hF07F);
    cycles(4);
    check("final_off", 32'(rgb_led), 32'h0000);
    cycles(4);
    check("final_on2", 32'(rgb_led), 32'hF07F);

    // FINISH latch / winner.
    score1 = 4'd4; score2 = 4'd7; is_finish = 1'b1;
    cycles(1);
    score1 = 4'd9;
    cycles(1);
    check("finish_winner", 32'(winner), 32'h2);
    check("finish_on", 32'(rgb_led), 32'hFF00);
    cycles(4);
    check("finish_off", 32'(rgb_led), 32'h0000);
    check("finish_winner2", 32'(winner), 32'h2);
    cycles(4);
    check("finish_on2", 32'(rgb_led), 32'hFF00);

    // Tie.
    is_finish = 1'b0; times = 1'b0; is_final = 1'b0;
    cycles(1);
    score1 = 4'd3; score2 = 4'd3; is_finish = 1'b1;
    cycles(2);
    check("tie_winner", 32'(winner), 32'h3);
    check("tie_on", 32'(rgb_led), 32'hFFFF);
    cycles(4);
    check("tie_off", 32'(rgb_led), 32'h0000);

    // Priority: all flags set still means FINISH, then drop to FINAL.
    times = 1'b1; is_final = 1'b1; score1 = 4'd7; score2 = 4'd4;
    cycles(2);
    check("prio_finish", 32'(winner), 32'h3);
    is_finish = 1'b0;
    cycles(2);
    check("prio_final_on", 32'(rgb_led), 32'hF07F);
    check("prio_final_win", 32'(winner), 32'h0);

    // Reset mid-operation.
    rst = 1'b1;
    cycles(1);
    check("rst_leds", 32'(rgb_led), 32'h0000);
    check("rst_winner", 32'(winner), 32'h0);
    rst = 1'b0; times = 1'b0; is_final = 1'b0;
    cycles(1);
    check("rst_idle_pos0", 32'(rgb_led), 32'h0001);

    // Randomized segments checked by the model.
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      logic [2:0] f;
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cycles($urandom_range(1, 3));
        rst = 1'b0;
      end
      f = 3'($urandom_range(0, 7));
      times = f[0]; is_final = f[1]; is_finish = f[2];
      score1 = SCORE_W'($urandom_range(0, 15));
      score2 = SCORE_W'($urandom_range(0, 15));
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) score1 = SCORE_W'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) score2 = SCORE_W'($urandom_range(0, 15));
        cycles(1);
      end
    end

    cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/standby_led_ng.md
# standby_led_ng

Parametrised next-generation LED status driver for the dice game. Sits between the game controller (round/final/finish flags, two player scores) and the on-board LED bank. It generalises the fixed 16-LED standby display with these features:

- configurable LED count and score width;
- tick-based animation;
- an idle chase pattern, score bars, a final-round blink and a winner display.

## Interface
- LED_W, 16: number of LEDs driven; must be even and ≥ 4; each player owns LED_W/2.
- SCORE_W, 4: width of each score input.
- TICK_DIV, 25_000_000: clk cycles per animation tick; ≥ 2.
- PWM_DUTY, 4: idle on-slots out of 16 (used only with STANDBY_PWM_EN); 1..16.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- times  in  1  round in progress.
- is_final  in  1  current round is the final round.
- is_finish  in  1  game over; highest priority.
- score1  in  SCORE_W  player 1 score, unsigned.
- score2  in  SCORE_W  player 2 score, unsigned.
- rgb_led  out  LED_W  LED drive, 1 = on; registered.
- winner  out  2  00 none, 01 P1, 10 P2, 11 tie; valid in FINISH only, else 00; registered.

## Operation
- Modes are registered in `state`. Next-state selection, in priority order:
  - is_finish → FINISH
  - times & is_final → FINAL
  - times → ROUND
  - otherwise → IDLE
- **Tick generator:**
  - tick_cnt counts 0..TICK_DIV-1; `tick` is a one-cycle pulse when tick_cnt = TICK_DIV-1, after which it wraps to 0.
  - Any state change clears tick_cnt and phase in that same cycle, so each mode starts in phase.
- **Bar rule:** half = LED_W/2.
  - n1 = min(score1, half); LEDs [n1-1:0] are on.
  - n2 = min(score2, half); LEDs [LED_W-1 : LED_W-n2] are on.
  - Scores above half saturate; a score of 0 gives an empty half.
- **IDLE:** one-hot chase.
  - pos starts at 0 when IDLE is entered and increments each tick.
  - pos wraps from LED_W-1 to 0.
  - rgb_led = 1 << pos.
- **ROUND:** rgb_led = bar(score1, score2), using live scores every cycle.
- **FINAL:**
  - phase toggles on each tick.
  - rgb_led = bar when phase = 0, all-off when phase = 1.
  - Scores are live.
- **FINISH:**
  - On the entry cycle, score1 and score2 are latched; later score changes are ignored.
  - winner is derived from the latched values.
  - phase toggles on each tick.
  - phase = 0: P1 win → lower half all-on; P2 win → upper half all-on; tie → all LEDs on.
  - phase = 1: all-off.
  - FINISH exits only when is_finish deasserts.
- **Simultaneous flags:** resolved strictly by the priority list; no error state.
- **rst mid-operation:** all registers return to their reset values on the next edge, regardless of state.

## Timing
- Reset values: state = IDLE, tick_cnt = 0, phase = 0, pos = 0, rgb_led = 0, winner = 00, latched scores = 0.
- First cycle after rst deasserts: state IDLE, pos 0; rgb_led = 1 one edge later.
- Latency:
  - Inputs sampled at edge k update state and latches at k.
  - rgb_led and winner reflect the change at edge k+1 (2-register path, fixed).
- In ROUND, a score change at edge k is visible on rgb_led at edge k+1.
- Animation period:
  - chase step = TICK_DIV cycles;
  - blink half-period = TICK_DIV cycles;
  - full blink = 2·TICK_DIV cycles.
- Input flags held for less than one cycle are not guaranteed to be captured. Inputs are synchronous to clk.

## Configuration
- **STANDBY_PWM_EN defined:**
  - A free-running 4-bit pwm_cnt, reset to 0, runs in all states.
  - In IDLE only, rgb_led is ANDed with (pwm_cnt < PWM_DUTY), which dims the chase.
  - Other modes are unaffected.
- **STANDBY_PWM_EN undefined:**
  - No pwm_cnt and no gating; IDLE runs at full brightness.
  - PWM_DUTY is ignored.

## Test plan
All scenarios use LED_W = 16, SCORE_W = 4, TICK_DIV = 4.

- **Reset/idle:** rst 1 for 3 cycles, then release; no flags set.
  - rgb_led = 0x0001, then shifts left every 4 cycles.
  - After 16 ticks it wraps to 0x0001.
  - winner = 00 throughout.
- **ROUND bars:** times = 1, score1 = 5, score2 = 3.
  - rgb_led = 0xE01F one cycle after state entry.
  - Changing to score1 = 12 (saturates) gives 0xE0FF one cycle later.
- **FINAL blink:** times = 1, is_final = 1, score1 = 7, score2 = 4.
  - rgb_led alternates 0xF07F and 0x0000 every 4 cycles, starting with 0xF07F.
- **FINISH latch/winner:** score1 = 4, score2 = 7, assert is_finish, then change score1 to 9.
  - winner = 10.
  - rgb_led alternates 0xFF00 and 0x0000 every 4 cycles.
  - The score change has no effect.
  - Tie case (score1 = score2 = 3): winner = 11 and rgb_led toggles 0xFFFF / 0x0000.
- **Priority/reset mid-op:** times = is_final = is_finish = 1 gives FINISH behaviour.
  - Deassert is_finish and the block enters FINAL, blink restarting with the bar shown.
  - Pulsing rst during FINAL gives rgb_led = 0 on the reset edge+1; after release the block is in IDLE with pos 0.
- **PWM (STANDBY_PWM_EN defined, PWM_DUTY = 4):**
  - In IDLE, the lit chase bit is high during pwm_cnt 0..3 and low during 4..15.
  - ROUND bars are ungated.
